booth_mult_arbiter: RTL and testbench
=====================================

# booth_mult_arbiter

Round-robin arbiter and sequencer that shares one 8x8 signed radix-4 Booth multiplier among NREQ requesters. It accepts one request at a time and drives the multiplier's level-held start/done protocol. It returns the 16-bit product to the granted requester with a one-cycle response pulse. It sits between the requesters and the single multiplier instance in the arithmetic cluster.

## Interface
- NREQ, 4: number of requesters, 2..8.
- CNTW, 16: width of completed-operation counter.

- CLK  input  1  single clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset. The multiplier's active-low reset is tied to ~RST at the parent.
- req_valid  input  NREQ  bit k: requester k has an operation pending. Held with operands until accepted.
- req_a  input  8*NREQ  signed multiplicand; requester k uses [8k+7:8k].
- req_b  input  8*NREQ  signed multiplier; requester k uses [8k+7:8k].
- req_ready  output  NREQ  one-hot accept; operands are sampled on the edge where valid&ready.
- rsp_valid  output  NREQ  one-hot, one-cycle pulse to the requester whose product is on rsp_product.
- rsp_product  output  16  signed product, valid while any rsp_valid bit is high.
- busy  output  1  high in RUN and RESP.
- op_count  output  CNTW  completed operations; wraps to 0.
- mul_start  output  1  multiplier Start_Sig (level).
- mul_a, mul_b  output  8 each  multiplier operands.
- mul_done  input  1  multiplier Done_Sig, a one-cycle pulse.
- mul_product  input  16  multiplier Product.

## Operation
- State machine: IDLE -> RUN -> RESP -> IDLE.
- **IDLE**
  - mul_start=0.
  - If any req_valid bit is set, grant k = the first set bit searching upward (with wrap) from last_grant+1.
  - req_ready[k]=1 combinationally in this cycle only.
  - On the edge: latch req_a/req_b slice k into op regs, set last_grant=k and gnt_id=k, go to RUN.
  - If no requests: stay in IDLE.
- **RUN**
  - mul_start=1; mul_a/mul_b = latched op regs, stable for the whole transaction.
  - On mul_done=1: latch mul_product into rsp_product, go to RESP. mul_start stays 1 in this cycle, because the multiplier self-returns to its idle step.
- **RESP**
  - mul_start=0; rsp_valid[gnt_id]=1; op_count += 1; go to IDLE.
- No requests are accepted in RUN or RESP. req_valid changes during those states have no effect.
- A requester that drops req_valid before it sees req_ready has withdrawn its request. This is legal.
- Arithmetic: two's complement. rsp_product is exactly the multiplier output, with no checking. Operand -128 for req_a is a requester error and its result is undefined.
- op_count wraps from 2^CNTW-1 to 0.
- Reset values: state=IDLE, last_grant=NREQ-1 (so requester 0 has highest priority first), op regs=0, rsp_product=0, op_count=0. All outputs are 0: req_ready, rsp_valid, busy, mul_start, mul_a, mul_b.
- Reset mid-operation: the in-flight op is discarded with no rsp_valid and mul_start drops the next cycle. The multiplier is reset by the same RST.

## Timing
- Accept edge T, where IDLE has req_ready high.
- T+1..T+7: RUN, mul_start high. The multiplier loads at T+1 and iterates T+2..T+5. It asserts done at T+7, and the product is stable from T+6.
- T+8: RESP, rsp_valid and rsp_product valid.
- T+9: IDLE; the next accept is possible in this cycle.
- Latency from accept to response is 8 cycles. Throughput is one op per 9 cycles.
- mul_done is used only as an event. RUN waits indefinitely, so there is no fixed-cycle assumption.
- Simultaneous requests: exactly one grant per IDLE cycle. Priority rotates after each grant.
- rsp_product holds its last value after RESP until the next response.

## Test plan
- **Single request:** req_valid=0001, a=3, b=5. Expect req_ready=0001 at T, rsp_valid=0001 at T+8, rsp_product=0x000F, op_count=1.
- **Signed operands:** requester 2, a=-2 (0xFE), b=7. Expect rsp_product=0xFFF2. Also a=127, b=127 gives 0x3F01, and a=-5, b=-9 gives 0x002D.
- **Rotation:** all four requesters valid continuously. Expect grant order 0,1,2,3,0. Accepts are 9 cycles apart. Each rsp_valid goes to the matching requester with its correct product.
- **Priority after idle gap:** grant requester 2, then requesters 1 and 3 request together. Expect 3 granted before 1.
- **Reset mid-op:** assert RST for 1 cycle at T+4. Expect no rsp_valid. All outputs are 0 on the next cycle and op_count=0. A new request then completes normally with 8-cycle latency.
- **Counter wrap:** CNTW=4, run 17 ops. Expect op_count to go 15 -> 0 -> 1.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// rtl/booth_mult_arbiter.sv - round-robin arbiter/sequencer sharing one 8x8 Booth multiplier
// Accepts one request per IDLE cycle, runs the multiplier start/done handshake, returns the product.
module booth_mult_arbiter #(
    parameter int NREQ = 4,
    parameter int CNTW = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [15:0]          rsp_product,
    output logic                 busy,
    output logic [CNTW-1:0]      op_count,
    output logic                 mul_start,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    input  logic                 mul_done,
    input  logic [15:0]          mul_product
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [IDW-1:0]  last_grant_q;
    logic [IDW-1:0]  gnt_id_q;
    logic [7:0]      op_a_q;
    logic [7:0]      op_b_q;
    logic [15:0]     prod_q;
    logic [CNTW-1:0] cnt_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic            mul_start_q;
    logic            busy_q;

    logic [IDW-1:0]  pick_d;
    logic            pick_vld_d;
    logic [IDW-1:0]  scan_idx;

    // Search upward from the requester after the last grant, wrapping; NREQ need not be a power of two.
    always_comb begin
        pick_d     = '0;
        pick_vld_d = 1'b0;
        scan_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            scan_idx = IDW'((int'(last_grant_q) + i) % NREQ);
            if (!pick_vld_d && req_valid[scan_idx]) begin
                pick_vld_d = 1'b1;
                pick_d     = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && pick_vld_d && !RST) begin
            req_ready = NREQ'(1) << pick_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            gnt_id_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            prod_q       <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= '0;
            mul_start_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        op_a_q       <= req_a[8*pick_d +: 8];
                        op_b_q       <= req_b[8*pick_d +: 8];
                        last_grant_q <= pick_d;
                        gnt_id_q     <= pick_d;
                        mul_start_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Start stays high through the done cycle; it falls on the edge into RESP.
                    if (mul_done) begin
                        prod_q      <= mul_product;
                        mul_start_q <= 1'b0;
                        rsp_valid_q <= NREQ'(1) << gnt_id_q;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid_q <= '0;
                    cnt_q       <= cnt_q + CNTW'(1);
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    rsp_valid_q <= '0;
                    mul_start_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = prod_q;
    assign busy        = busy_q;
    assign op_count    = cnt_q;
    assign mul_start   = mul_start_q;
    assign mul_a       = op_a_q;
    assign mul_b       = op_b_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb/tb_booth_mult_arbiter.sv - directed table-driven bench for booth_mult_arbiter
module tb_booth_mult_arbiter;
    localparam int NREQ = 4;
    localparam int CNTW = 4;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_a = '0;
    logic [8*NREQ-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [15:0]       rsp_product;
    logic              busy;
    logic [CNTW-1:0]   op_count;
    logic              mul_start;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic              mul_done = 1'b0;
    logic [15:0]       mul_product;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int cyc = 0;
    int grant_cyc = 0;
    logic [2:0] m_cnt = '0;

    booth_mult_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_product(rsp_product), .busy(busy), .op_count(op_count),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Multiplier stand-in: done pulses in the 7th cycle of start being high.
    always @(posedge CLK) begin
        if (RST || !mul_start || mul_done) begin
            m_cnt    <= '0;
            mul_done <= 1'b0;
        end else begin
            m_cnt    <= m_cnt + 3'd1;
            mul_done <= (m_cnt == 3'd5);
        end
    end
    assign mul_product = {{8{mul_a[7]}}, mul_a} * {{8{mul_b[7]}}, mul_b};

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        req_valid = '0;
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic wait_grant(input logic [NREQ-1:0] mask, input bit at_neg);
        int n;
        n = 0;
        if (!at_neg) @(negedge CLK);
        while (req_ready == '0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("grant", req_ready, mask);
        grant_cyc = cyc;
    endtask

    task automatic wait_resp(input logic [NREQ-1:0] mask, input logic [15:0] prod,
                             input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                chk("run_start", mul_start, 1);
                chk("run_busy", busy, 1);
                chk("run_a", mul_a, a);
                chk("run_b", mul_b, b);
            end
        end while (rsp_valid == '0 && n < 40);
        chk("latency", n, 8);
        chk("rsp_valid", rsp_valid, mask);
        chk("rsp_product", rsp_product, prod);
        exp_cnt++;
        @(negedge CLK);
        chk("rsp_pulse", rsp_valid, 0);
        chk("op_count", op_count, 32'(exp_cnt % 16));
        chk("rsp_hold", rsp_product, prod);
        chk("idle_busy", busy, 0);
    endtask

    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic [15:0] prod);
        @(posedge CLK); #1;
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
        req_valid = NREQ'(1) << id;
        wait_grant(NREQ'(1) << id, 1'b0);
        @(posedge CLK); #1;
        req_valid = '0;
        wait_resp(NREQ'(1) << id, prod, a, b);
    endtask

    initial begin
        int last_cyc;
        int seen;
        int order[5];
        logic [15:0] rot_prod[4];
        logic [7:0]  rot_a[4];
        logic [7:0]  rot_b[4];

        vecs[0] = '{0, 8'd3,   8'd5,   16'h000F};
        vecs[1] = '{2, 8'hFE,  8'd7,   16'hFFF2};
        vecs[2] = '{1, 8'd127, 8'd127, 16'h3F01};
        vecs[3] = '{3, 8'hFB,  8'hF7,  16'h002D};
        vecs[4] = '{1, 8'hFF,  8'hFF,  16'h0001};
        vecs[5] = '{3, 8'd100, 8'hFD,  16'hFED4};

        do_reset();
        @(negedge CLK);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_product", rsp_product, 0);
        chk("rst_op_count", op_count, 0);

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].prod);
        end

        // Rotation: all four hold requests; grants must go 0,1,2,3,0 nine cycles apart.
        do_reset();
        rot_a[0] = 8'd3;   rot_b[0] = 8'd5;   rot_prod[0] = 16'h000F;
        rot_a[1] = 8'd127; rot_b[1] = 8'd127; rot_prod[1] = 16'h3F01;
        rot_a[2] = 8'hFE;  rot_b[2] = 8'd7;   rot_prod[2] = 16'hFFF2;
        rot_a[3] = 8'hFB;  rot_b[3] = 8'hF7;  rot_prod[3] = 16'h002D;
        order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 4; k++) begin
            req_a[8*k +: 8] = rot_a[k];
            req_b[8*k +: 8] = rot_b[k];
        end
        req_valid = 4'b1111;
        last_cyc = 0;
        for (int g = 0; g < 5; g++) begin
            wait_grant(NREQ'(1) << order[g], g != 0);
            if (g != 0) chk("accept_spacing", grant_cyc - last_cyc, 9);
            last_cyc = grant_cyc;
            @(posedge CLK); #1;
            if (g == 4) req_valid = '0;
            wait_resp(NREQ'(1) << order[g], rot_prod[order[g]], rot_a[order[g]], rot_b[order[g]]);
        end

        // Priority after idle gap: after granting 2, a tie between 1 and 3 goes to 3.
        do_op(2, 8'd2, 8'd2, 16'h0004);
        @(posedge CLK); #1;
        req_a[8 +: 8]  = 8'hFF; req_b[8 +: 8]  = 8'hFF;
        req_a[24 +: 8] = 8'd100; req_b[24 +: 8] = 8'hFD;
        req_valid = 4'b1010;
        wait_grant(4'b1000, 1'b0);
        @(posedge CLK); #1;
        req_valid = 4'b0010;
        wait_resp(4'b1000, 16'hFED4, 8'd100, 8'hFD);
        wait_grant(4'b0010, 1'b1);
        @(posedge CLK); #1;
        req_valid = '0;
        wait_resp(4'b0010, 16'h0001, 8'hFF, 8'hFF);

        // Reset in the middle of a transaction at T+4.
        @(posedge CLK); #1;
        req_a[8 +: 8] = 8'd4; req_b[8 +: 8] = 8'd6;
        req_valid = 4'b0010;
        wait_grant(4'b0010, 1'b0);
        @(posedge CLK); #1;
        req_valid = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_cnt = 0;
        @(negedge CLK);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mul_start", mul_start, 0);
        chk("mid_rst_mul_a", mul_a, 0);
        chk("mid_rst_mul_b", mul_b, 0);
        chk("mid_rst_op_count", op_count, 0);
        chk("mid_rst_product", rsp_product, 0);
        seen = 0;
        repeat (12) begin
            @(negedge CLK);
            if (rsp_valid != '0 || busy) seen++;
        end
        chk("mid_rst_no_rsp", seen, 0);
        do_op(1, 8'd4, 8'd6, 16'h0018);

        // Counter wrap with a 4-bit op counter: 15 -> 0 -> 1.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            do_op(i % 4, 8'(i + 1), 8'd2, 16'((i + 1) * 2));
            if (i == 14) chk("wrap_15", op_count, 15);
            if (i == 15) chk("wrap_0", op_count, 0);
            if (i == 16) chk("wrap_1", op_count, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
